// File: rtl/sw_debounce_if.sv
// Switch bundle between the raw pins and the debouncer.
// Master drives raw pins, slave returns clean levels and edge pulses.
interface sw_debounce_if #(
  parameter int NUM_SW = 3
);
  logic [NUM_SW-1:0] sw;
  logic [NUM_SW-1:0] sw_db;
  logic [NUM_SW-1:0] sw_rise;
  logic [NUM_SW-1:0] sw_fall;

  modport master (
    output sw,
    input  sw_db,
    input  sw_rise,
    input  sw_fall
  );

  modport slave (
    input  sw,
    output sw_db,
    output sw_rise,
    output sw_fall
  );
endinterface

// File: rtl/sw_debounce.sv
// Per-channel 2-FF synchroniser and counter debouncer.
// Emits clean levels plus registered one-cycle rise/fall pulses.
module sw_debounce #(
  parameter int NUM_SW          = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SW_ACTIVE_LOW   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  sw_debounce_if.slave  bus
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_SW-1:0] POL =
    (SW_ACTIVE_LOW != 0) ? '1 : '0;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("sw_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [NUM_SW-1:0] lvl;
  logic [NUM_SW-1:0] s1_q;
  logic [NUM_SW-1:0] s2_q;
  logic [NUM_SW-1:0] db_q;
  logic [NUM_SW-1:0] db_d;
  logic [NUM_SW-1:0] rise_q;
  logic [NUM_SW-1:0] rise_d;
  logic [NUM_SW-1:0] fall_q;
  logic [NUM_SW-1:0] fall_d;
  logic [CW-1:0]     cnt_q [NUM_SW];
  logic [CW-1:0]     cnt_d [NUM_SW];

  assign lvl = bus.sw ^ POL;

  // Count consecutive mismatches; accept the new level on the last one.
  always_comb begin
    db_d  = db_q;
    cnt_d = '{default: '0};
    for (int i = 0; i < NUM_SW; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CMAX) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    rise_d = db_d & ~db_q;
    fall_d = ~db_d & db_q;
  end

  // Sync chain, counters, level and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      cnt_q  <= '{default: '0};
    end else begin
      s1_q   <= lvl;
      s2_q   <= s1_q;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.sw_db   = db_q;
  assign bus.sw_rise = rise_q;
  assign bus.sw_fall = fall_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce.
// Two instances: active-high and active-low pin polarity.
module tb_sw_debounce;

  logic clk;
  logic rst_n;
  logic rst2_n;
  int   n_tests;
  int   n_fail;
  int   rcnt;

  sw_debounce_if #(.NUM_SW(3)) bus0 ();
  sw_debounce_if #(.NUM_SW(3)) bus1 ();

  sw_debounce #(
    .NUM_SW(3),
    .DEBOUNCE_CYCLES(4),
    .SW_ACTIVE_LOW(0)
  ) u_hi (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  sw_debounce #(
    .NUM_SW(3),
    .DEBOUNCE_CYCLES(4),
    .SW_ACTIVE_LOW(1)
  ) u_lo (
    .clk  (clk),
    .rst_n(rst2_n),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rcnt    = 0;
    rst_n   = 1'b0;
    rst2_n  = 1'b0;
    bus0.sw = 3'b111;
    bus1.sw = 3'b111;

    // 1: reset with all switches active
    tick(3);
    chk("rst_db",   32'(bus0.sw_db),   32'h0);
    chk("rst_rise", 32'(bus0.sw_rise), 32'h0);
    chk("rst_fall", 32'(bus0.sw_fall), 32'h0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    tick(5);
    chk("rel_db_e5",   32'(bus0.sw_db),   32'h0);
    tick(1);
    chk("rel_db_e6",   32'(bus0.sw_db),   32'h7);
    chk("rel_rise_e6", 32'(bus0.sw_rise), 32'h7);
    tick(1);
    chk("rel_rise_e7", 32'(bus0.sw_rise), 32'h0);
    chk("rel_db_e7",   32'(bus0.sw_db),   32'h7);

    // return to idle, all channels fall together
    bus0.sw = 3'b000;
    tick(6);
    chk("idle_fall", 32'(bus0.sw_fall), 32'h7);
    chk("idle_db",   32'(bus0.sw_db),   32'h0);
    tick(2);

    // 2: clean edge on channel 0
    bus0.sw[0] = 1'b1;
    tick(5);
    chk("clean_db_e5",   32'(bus0.sw_db),   32'h0);
    tick(1);
    chk("clean_db_e6",   32'(bus0.sw_db),   32'h1);
    chk("clean_rise_e6", 32'(bus0.sw_rise), 32'h1);
    tick(1);
    chk("clean_rise_e7", 32'(bus0.sw_rise), 32'h0);
    bus0.sw[0] = 1'b0;
    tick(5);
    chk("clean_fall_e5", 32'(bus0.sw_fall), 32'h0);
    tick(1);
    chk("clean_fall_e6", 32'(bus0.sw_fall), 32'h1);
    chk("clean_db_lo",   32'(bus0.sw_db),   32'h0);
    tick(1);
    chk("clean_fall_e7", 32'(bus0.sw_fall), 32'h0);
    tick(2);

    // 3: bounce on channel 1, then settle high
    rcnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus0.sw[1] = ((i / 2) % 2 == 0);
      tick(1);
      rcnt += int'(bus0.sw_rise[1]);
      chk("bounce_db", 32'(bus0.sw_db[1]), 32'h0);
    end
    bus0.sw[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      rcnt += int'(bus0.sw_rise[1]);
      chk("bounce_settle_db", 32'(bus0.sw_db[1]), 32'h0);
    end
    tick(1);
    rcnt += int'(bus0.sw_rise[1]);
    chk("bounce_db_e6",   32'(bus0.sw_db),   32'h2);
    chk("bounce_rise_e6", 32'(bus0.sw_rise), 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      rcnt += int'(bus0.sw_rise[1]);
    end
    chk("bounce_rise_cnt", 32'(rcnt), 32'd1);
    bus0.sw[1] = 1'b0;
    tick(6);
    chk("bounce_fall", 32'(bus0.sw_fall), 32'h2);
    tick(2);

    // 4: 3-cycle glitch on channel 2
    bus0.sw[2] = 1'b1;
    tick(3);
    bus0.sw[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("glitch_db",   32'(bus0.sw_db[2]),   32'h0);
      chk("glitch_rise", 32'(bus0.sw_rise[2]), 32'h0);
      chk("glitch_fall", 32'(bus0.sw_fall[2]), 32'h0);
      tick(1);
    end

    // 5: channels 0 and 2 together
    bus0.sw = 3'b101;
    tick(5);
    chk("indep_db_e5",   32'(bus0.sw_db),   32'h0);
    tick(1);
    chk("indep_db_e6",   32'(bus0.sw_db),   32'h5);
    chk("indep_rise_e6", 32'(bus0.sw_rise), 32'h5);
    tick(1);
    chk("indep_rise_e7", 32'(bus0.sw_rise), 32'h0);
    bus0.sw = 3'b000;
    tick(6);
    chk("indep_fall", 32'(bus0.sw_fall), 32'h5);

    // 6: active-low instance, idle pins high
    chk("lo_idle_db", 32'(bus1.sw_db), 32'h0);
    bus1.sw[0] = 1'b0;
    tick(5);
    chk("lo_db_e5", 32'(bus1.sw_db), 32'h0);
    tick(1);
    chk("lo_db_e6",   32'(bus1.sw_db),   32'h1);
    chk("lo_rise_e6", 32'(bus1.sw_rise), 32'h1);
    bus1.sw[0] = 1'b1;
    tick(6);
    chk("lo_fall", 32'(bus1.sw_fall), 32'h1);
    chk("lo_db_off", 32'(bus1.sw_db), 32'h0);
    tick(2);

    // reset mid-count, then full latency again
    bus1.sw[0] = 1'b0;
    tick(3);
    rst2_n = 1'b0;
    #1;
    chk("lo_midrst_db", 32'(bus1.sw_db), 32'h0);
    tick(2);
    chk("lo_midrst_rise", 32'(bus1.sw_rise), 32'h0);
    chk("lo_midrst_fall", 32'(bus1.sw_fall), 32'h0);
    rst2_n = 1'b1;
    rcnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      rcnt += int'(bus1.sw_rise[0]);
      chk("lo_rel_db", 32'(bus1.sw_db), 32'h0);
    end
    chk("lo_rel_no_pulse", 32'(rcnt), 32'd0);
    tick(1);
    chk("lo_rel_db_e6",   32'(bus1.sw_db),   32'h1);
    chk("lo_rel_rise_e6", 32'(bus1.sw_rise), 32'h1);
    tick(1);
    chk("lo_rel_rise_e7", 32'(bus1.sw_rise), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
